// File: rtl/leaf_rx_pkg.sv
// Shared definitions for the leaf receiver: header field prefixes, hop classes, FIFO entry layout.
package leaf_rx_pkg;

  localparam int unsigned FLIT_W    = 9;
  localparam int unsigned PAYLOAD_W = 8;
  localparam int unsigned HOPS_W    = 2;
  localparam int unsigned CNT_W     = 16;

  localparam logic       HDR_SIB   = 1'b1;
  localparam logic [1:0] HDR_HALF  = 2'b01;
  localparam logic [2:0] HDR_CROSS = 3'b001;

  typedef enum logic [HOPS_W-1:0] {
    HOPS_NONE  = 2'd0,
    HOPS_SIB   = 2'd1,
    HOPS_HALF  = 2'd2,
    HOPS_CROSS = 2'd3
  } hops_e;

  typedef struct packed {
    logic [PAYLOAD_W-1:0] payload;
    hops_e                hops;
  } rx_entry_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } rx_state_e;

  // Strip the routing prefix; HOPS_NONE marks an illegal header.
  function automatic rx_entry_t decode_flit(input logic [FLIT_W-1:0] d);
    rx_entry_t e;
    e.payload = '0;
    e.hops    = HOPS_NONE;
    if (d[8] == HDR_SIB) begin
      e.payload = d[7:0];
      e.hops    = HOPS_SIB;
    end else if (d[8:7] == HDR_HALF) begin
      e.payload = PAYLOAD_W'(d[5:0]);
      e.hops    = HOPS_HALF;
    end else if (d[8:6] == HDR_CROSS) begin
      e.payload = PAYLOAD_W'(d[3:0]);
      e.hops    = HOPS_CROSS;
    end
    return e;
  endfunction

endpackage

// File: rtl/leaf_rx_fifo.sv
// Synchronous payload FIFO with valid/ready head and a full flag.
module rx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          ready,
  output logic          valid,
  output logic [DW-1:0] head,
  output logic          full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign valid   = (cnt_q != '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign head    = mem_q[rd_q];
  assign do_push = push && !full;
  assign do_pop  = valid && ready;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (do_push) begin
      mem_d[wr_q] = push_data;
      wr_d        = wr_q + AW'(1);
    end
    if (do_pop) begin
      rd_d = rd_q + AW'(1);
    end
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/leaf_rx.sv
// Leaf endpoint: 4-phase req/ack capture, header strip, payload FIFO and packet/error counters.
module leaf_rx import leaf_rx_pkg::*; #(
  parameter int unsigned WIDTH       = 9,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_req,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 in_ack,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [HOPS_W-1:0]    out_hops,
  output logic [CNT_W-1:0]     pkt_count,
  output logic [CNT_W-1:0]     err_count
);

  localparam int unsigned EW = $bits(rx_entry_t);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   req_s;
  rx_state_e              state_q, state_d;
  logic                   ack_q, ack_d;
  logic                   pend_q, pend_d;
  logic [WIDTH-1:0]       cap_q, cap_d;
  logic [CNT_W-1:0]       pkt_q, pkt_d, err_q, err_d;
  rx_entry_t              entry, head;
  logic [EW-1:0]          head_vec;
  logic                   legal, fifo_full;

  // in_req synchronizer chain
  assign sync_d[0] = in_req;
  for (genvar i = 1; i < SYNC_STAGES; i++) begin : g_sync
    assign sync_d[i] = sync_q[i-1];
  end
  assign req_s = sync_q[SYNC_STAGES-1];

  // The captured flit is decoded and committed one cycle after capture.
  assign entry = decode_flit(FLIT_W'(cap_q));
  assign legal = (entry.hops != HOPS_NONE);

  always_comb begin
    state_d = state_q;
    ack_d   = ack_q;
    cap_d   = cap_q;
    pend_d  = 1'b0;
    pkt_d   = pkt_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_s && !fifo_full) begin
          state_d = ST_ACK;
          ack_d   = 1'b1;
          cap_d   = in_data;
          pend_d  = 1'b1;
        end
      end
      ST_ACK: begin
        if (!req_s) begin
          state_d = ST_IDLE;
          ack_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (pend_q && legal && (pkt_q != '1)) pkt_d = pkt_q + CNT_W'(1);
    if (pend_q && !legal && (err_q != '1)) err_d = err_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      pend_q  <= 1'b0;
      cap_q   <= '0;
      pkt_q   <= '0;
      err_q   <= '0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      ack_q   <= ack_d;
      pend_q  <= pend_d;
      cap_q   <= cap_d;
      pkt_q   <= pkt_d;
      err_q   <= err_d;
    end
  end

  rx_fifo #(
    .DEPTH (DEPTH),
    .DW    (EW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (pend_q && legal),
    .push_data (entry),
    .ready     (out_ready),
    .valid     (out_valid),
    .head      (head_vec),
    .full      (fifo_full)
  );

  assign head        = rx_entry_t'(head_vec);
  assign out_payload = head.payload;
  assign out_hops    = head.hops;
  assign in_ack      = ack_q;
  assign pkt_count   = pkt_q;
  assign err_count   = err_q;

endmodule

// File: tb/tb_leaf_rx.sv
// Self-checking bench for leaf_rx: vector table, directed corner cases, randomized traffic vs model.
module tb_leaf_rx;

  logic        clk = 1'b0;
  logic        rst, in_req, in_ack, out_valid, out_ready;
  logic [8:0]  in_data;
  logic [7:0]  out_payload;
  logic [1:0]  out_hops;
  logic [15:0] pkt_count, err_count;

  int total = 0;
  int bad   = 0;
  bit rand_ready = 0;
  bit mon_en = 0;
  int exp_q[$];
  int m_pkt = 0;
  int m_err = 0;

  typedef struct {
    logic [8:0] flit;
    logic [7:0] pay;
    logic [1:0] hops;
  } vec_t;
  vec_t tbl[6];

  leaf_rx dut (
    .clk(clk), .rst(rst), .in_req(in_req), .in_data(in_data), .in_ack(in_ack),
    .out_valid(out_valid), .out_ready(out_ready), .out_payload(out_payload),
    .out_hops(out_hops), .pkt_count(pkt_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference decode from the header rules, by value ranges.
  function automatic int ref_hops(input int v);
    if (v >= 256) return 1;
    if (v >= 128) return 2;
    if (v >= 64) return 3;
    return 0;
  endfunction

  function automatic int ref_payload(input int v);
    case (ref_hops(v))
      1: return v - 256;
      2: return v % 64;
      3: return v % 16;
      default: return 0;
    endcase
  endfunction

  task automatic model_accept(input logic [8:0] f);
    int v = int'(f);
    if (ref_hops(v) != 0) begin
      exp_q.push_back(ref_payload(v) * 4 + ref_hops(v));
      if (m_pkt < 65535) m_pkt++;
    end else begin
      if (m_err < 65535) m_err++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_ack(input logic lvl, input int budget, output int n);
    n = 0;
    while (in_ack !== lvl && n < budget) begin
      tick();
      n++;
    end
    if (in_ack !== lvl) check("ack_timeout", 32'(in_ack), 32'(lvl));
  endtask

  task automatic send(input logic [8:0] f);
    int n;
    tick();
    in_data = f;
    in_req  = 1'b1;
    wait_ack(1'b1, 400, n);
    model_accept(f);
    in_req = 1'b0;
    wait_ack(1'b0, 400, n);
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    out_ready = 1'b1;
    while (out_valid && n < 100) begin
      tick();
      n++;
    end
    out_ready = 1'b0;
    check({name, "_valid"}, 32'(out_valid), 0);
    check({name, "_left"}, 32'(exp_q.size()), 0);
  endtask

  task automatic check_head(input string name, input logic [7:0] pay, input logic [1:0] hops);
    check({name, "_valid"}, 32'(out_valid), 1);
    check({name, "_payload"}, 32'(out_payload), 32'(pay));
    check({name, "_hops"}, 32'(out_hops), 32'(hops));
  endtask

  // Every accepted head is compared with the model queue in order.
  always @(negedge clk) begin
    if (mon_en && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("unexpected_pop", 32'(out_valid), 0);
      else check("pop_head", {22'd0, out_payload, out_hops}, 32'(exp_q.pop_front()));
    end
  end

  initial begin
    int n;
    tbl[0] = '{9'h100, 8'h00, 2'd1};
    tbl[1] = '{9'h1A5, 8'hA5, 2'd1};
    tbl[2] = '{9'b010111111, 8'h3F, 2'd2};
    tbl[3] = '{9'b011000001, 8'h01, 2'd2};
    tbl[4] = '{9'b001011111, 8'h0F, 2'd3};
    tbl[5] = '{9'b001110110, 8'h06, 2'd3};

    rst = 1'b1; in_req = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) tick();
    check("rst_ack", 32'(in_ack), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_payload", 32'(out_payload), 0);
    check("rst_hops", 32'(out_hops), 0);
    check("rst_pkt", 32'(pkt_count), 0);
    check("rst_err", 32'(err_count), 0);
    rst = 1'b0;
    mon_en = 1;
    tick();

    // Sibling flit: latency and registered head timing
    in_data = 9'b100000000; in_req = 1'b1;
    wait_ack(1'b1, 20, n);
    check("rise_latency", 32'(n), 3);
    check("valid_at_capture", 32'(out_valid), 0);
    model_accept(9'b100000000);
    tick();
    check_head("t1", 8'h00, 2'd1);
    check("t1_pkt", 32'(pkt_count), 1);
    in_req = 1'b0;
    wait_ack(1'b0, 20, n);
    check("fall_latency", 32'(n), 3);
    pop_one();

    // Ordering of two queued entries
    send(9'b010111111);
    send(9'b001011111);
    tick();
    check_head("ord0", 8'h3F, 2'd2);
    pop_one();
    check_head("ord1", 8'h0F, 2'd3);
    pop_one();

    // Illegal header: acked, dropped, counted
    send(9'b000101010);
    repeat (3) tick();
    check("ill_valid", 32'(out_valid), 0);
    check("ill_err", 32'(err_count), 1);
    check("ill_pkt", 32'(pkt_count), 3);

    for (int i = 0; i < 6; i++) begin
      send(tbl[i].flit);
      tick();
      check_head($sformatf("tbl%0d", i), tbl[i].pay, tbl[i].hops);
      pop_one();
    end

    // Backpressure: fifth flit stalls until one slot frees
    for (int i = 0; i < 4; i++) send(9'(9'h110 + i));
    tick();
    in_data = 9'h1EE; in_req = 1'b1;
    repeat (20) tick();
    check("bp_stall_ack", 32'(in_ack), 0);
    check("bp_full_valid", 32'(out_valid), 1);
    pop_one();
    wait_ack(1'b1, 20, n);
    check("bp_release_ack", 32'(in_ack), 1);
    model_accept(9'h1EE);
    in_req = 1'b0;
    wait_ack(1'b0, 20, n);
    drain("bp_drain");

    // Randomized traffic with random consumer readiness
    rand_ready = 1;
    for (int i = 0; i < 60; i++) send(9'($urandom_range(0, 511)));
    rand_ready = 0;
    drain("rnd_drain");
    check("rnd_pkt", 32'(pkt_count), 32'(m_pkt));
    check("rnd_err", 32'(err_count), 32'(m_err));

    // Reset while in_ack is high, request held through reset
    tick();
    in_data = 9'h1C3; in_req = 1'b1;
    wait_ack(1'b1, 20, n);
    rst = 1'b1;
    tick();
    check("mrst_ack", 32'(in_ack), 0);
    check("mrst_valid", 32'(out_valid), 0);
    check("mrst_payload", 32'(out_payload), 0);
    check("mrst_hops", 32'(out_hops), 0);
    check("mrst_pkt", 32'(pkt_count), 0);
    check("mrst_err", 32'(err_count), 0);
    exp_q.delete(); m_pkt = 0; m_err = 0;
    rst = 1'b0;
    wait_ack(1'b1, 20, n);
    check("mrst_recapture_latency", 32'(n), 3);
    model_accept(9'h1C3);
    in_req = 1'b0;
    wait_ack(1'b0, 20, n);
    tick();
    check_head("mrst_head", 8'hC3, 2'd1);
    check("mrst_pkt_after", 32'(pkt_count), 1);
    pop_one();

    // Saturation of the packet counter
    tick();
    force dut.pkt_q = 16'hFFFF;
    tick();
    release dut.pkt_q;
    m_pkt = 65535;
    send(9'h0B7);
    tick();
    check("sat_pkt", 32'(pkt_count), 32'hFFFF);
    check_head("sat_head", 8'h37, 2'd2);
    pop_one();
    check("sat_model_pkt", 32'(pkt_count), 32'(m_pkt));

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
